// File: rtl/data_memory_bytelane.sv
// -----------------------------------------------------------------------------
// data_memory_bytelane
//   Byte-addressed data memory for the MEM stage. Each word is DATA_WIDTH bits
//   and holds LANE = DATA_WIDTH/8 byte lanes. It supports byte, half, word and
//   double accesses, with signed or unsigned sub-word loads. A valid/ready
//   request handshake gives a fixed READ_LATENCY, and the Fault flag reports
//   misaligned, out-of-range or illegal-size accesses.
//
// Ports
//   Clock      in   rising-edge clock
//   ResetN     in   asynchronous active-low reset
//   ReqValid   in   request present
//   ReqReady   out  block can accept a request (IDLE only)
//   ReqWrite   in   1 = store, 0 = load
//   ReqSize    in   00 byte, 01 half, 10 word, 11 double
//   ReqSigned  in   loads: 1 = sign-extend, 0 = zero-extend
//   Address    in   byte address
//   WriteData  in   store data, right-justified
//   RespValid  out  one-cycle response pulse, READ_LATENCY edges after accept
//   ReadData   out  load result, right-justified and extended (0 for stores)
//   Fault      out  qualified by RespValid: the access faulted
// -----------------------------------------------------------------------------
module data_memory_bytelane #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 256,
  parameter int ADDR_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  Clock,
  input  logic                  ResetN,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic                  ReqWrite,
  input  logic [1:0]            ReqSize,
  input  logic                  ReqSigned,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic                  RespValid,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  Fault
);

  localparam int LANE  = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(LANE);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

  state_e                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
  logic                  fault_q, fault_d;

  // Request captured at the acceptance edge.
  logic                  req_write_q, req_signed_q, req_fault_q;
  logic [1:0]            req_size_q;
  logic [OFF_W-1:0]      req_off_q;
  logic [DATA_WIDTH-1:0] req_word_q;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  accept;
  logic [OFF_W-1:0]      off;
  logic [IDX_W-1:0]      idx;
  logic                  misaligned, out_of_range, bad_size, req_fault;
  logic [LANE-1:0]       size_mask, byte_en;
  logic [DATA_WIDTH-1:0] wdata_sh;
  logic [DATA_WIDTH-1:0] load_shifted, load_mask, load_ext;
  logic                  load_sign;

  assign accept = ReqValid & ready_q;
  assign off    = Address[OFF_W-1:0];
  assign idx    = Address[OFF_W +: IDX_W];

  // ---------------------------------------------------------------------------
  // Request decode: fault detection and store byte enables
  // ---------------------------------------------------------------------------
  // IDX >= DEPTH is the same as the byte address passing the end of storage.
  assign out_of_range = (Address >= ADDR_WIDTH'(DEPTH * LANE));
  assign bad_size     = (ReqSize == 2'b11) && (DATA_WIDTH == 32);
  assign req_fault    = misaligned | out_of_range | bad_size;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    misaligned = 1'b0;
    size_mask  = '1;
    case (ReqSize)
      2'b00: size_mask = LANE'(1);
      2'b01: begin
        misaligned = Address[0];
        size_mask  = LANE'(2'b11);
      end
      2'b10: begin
        misaligned = |Address[1:0];
        size_mask  = LANE'(4'hF);
      end
      default: misaligned = |Address[2:0];
    endcase
    byte_en  = size_mask << off;
    wdata_sh = WriteData << {off, 3'b000};
  end

  // NOTE: the storage array has no reset branch; its contents survive ResetN
  // and it maps onto plain RAM.
  always_ff @(posedge Clock) begin
    if (accept && ReqWrite && !req_fault) begin
      for (int b = 0; b < LANE; b++) begin
        if (byte_en[b]) mem_q[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Load extraction from the word captured at acceptance
  // ---------------------------------------------------------------------------
  always_comb begin
    load_shifted = req_word_q >> {req_off_q, 3'b000};
    load_mask    = '1;
    load_sign    = load_shifted[DATA_WIDTH-1];
    case (req_size_q)
      2'b00: begin
        load_mask = DATA_WIDTH'(8'hFF);
        load_sign = load_shifted[7];
      end
      2'b01: begin
        load_mask = DATA_WIDTH'(16'hFFFF);
        load_sign = load_shifted[15];
      end
      2'b10: begin
        load_mask = DATA_WIDTH'(32'hFFFF_FFFF);
        load_sign = load_shifted[31];
      end
      default: ;
    endcase
    load_ext = load_shifted & load_mask;
    // A full-width mask makes ~load_mask zero, so ReqSigned has no effect there.
    if (req_signed_q && load_sign) load_ext = load_ext | ~load_mask;
  end

  // ---------------------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_valid_d = 1'b0;
    read_data_d  = read_data_q;
    fault_d      = fault_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_BUSY;
          cnt_d   = 2'(READ_LATENCY - 1);
        end
      end
      default: begin
        if (cnt_q == 2'd0) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b1;
          read_data_d  = (req_write_q || req_fault_q) ? '0 : load_ext;
          fault_d      = req_fault_q;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
    endcase
    // Registered so ReqReady stays low through reset and rises one edge later.
    ready_d = (state_d == ST_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples the values from before the edge.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      read_data_q  <= '0;
      fault_q      <= 1'b0;
      req_write_q  <= 1'b0;
      req_signed_q <= 1'b0;
      req_fault_q  <= 1'b0;
      req_size_q   <= '0;
      req_off_q    <= '0;
      req_word_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      read_data_q  <= read_data_d;
      fault_q      <= fault_d;
      if (accept) begin
        req_write_q  <= ReqWrite;
        req_signed_q <= ReqSigned;
        req_fault_q  <= req_fault;
        req_size_q   <= ReqSize;
        req_off_q    <= off;
        req_word_q   <= mem_q[idx];
      end
    end
  end

  assign ReqReady  = ready_q;
  assign RespValid = resp_valid_q;
  assign ReadData  = read_data_q;
  assign Fault     = fault_q;

endmodule

// File: tb/tb_data_memory_bytelane.sv
// -----------------------------------------------------------------------------
// tb_data_memory_bytelane
//   Three instances of data_memory_bytelane share one clock:
//     0: 32-bit, latency 1   1: 32-bit, latency 3   2: 64-bit, latency 2
//   A table of directed vectors drives them first. Hand-written sequences then
//   cover back-to-back acceptance and reset while busy. Random traffic follows,
//   checked against a byte-array reference model.
// -----------------------------------------------------------------------------
module tb_data_memory_bytelane;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n      [3];
  logic        req_valid  [3];
  logic        req_write  [3];
  logic        req_signed [3];
  logic [1:0]  req_size   [3];
  logic [31:0] addr       [3];
  logic        req_ready  [3];
  logic        resp_valid [3];
  logic        fault      [3];
  logic [31:0] wd0, wd1, rd0, rd1;
  logic [63:0] wd2, rd2;

  data_memory_bytelane #(.DATA_WIDTH(32), .DEPTH(256), .ADDR_WIDTH(32), .READ_LATENCY(1)) u_d0 (
    .Clock(clk), .ResetN(rst_n[0]), .ReqValid(req_valid[0]), .ReqReady(req_ready[0]),
    .ReqWrite(req_write[0]), .ReqSize(req_size[0]), .ReqSigned(req_signed[0]),
    .Address(addr[0]), .WriteData(wd0), .RespValid(resp_valid[0]), .ReadData(rd0),
    .Fault(fault[0]));

  data_memory_bytelane #(.DATA_WIDTH(32), .DEPTH(256), .ADDR_WIDTH(32), .READ_LATENCY(3)) u_d1 (
    .Clock(clk), .ResetN(rst_n[1]), .ReqValid(req_valid[1]), .ReqReady(req_ready[1]),
    .ReqWrite(req_write[1]), .ReqSize(req_size[1]), .ReqSigned(req_signed[1]),
    .Address(addr[1]), .WriteData(wd1), .RespValid(resp_valid[1]), .ReadData(rd1),
    .Fault(fault[1]));

  data_memory_bytelane #(.DATA_WIDTH(64), .DEPTH(256), .ADDR_WIDTH(32), .READ_LATENCY(2)) u_d2 (
    .Clock(clk), .ResetN(rst_n[2]), .ReqValid(req_valid[2]), .ReqReady(req_ready[2]),
    .ReqWrite(req_write[2]), .ReqSize(req_size[2]), .ReqSigned(req_signed[2]),
    .Address(addr[2]), .WriteData(wd2), .RespValid(resp_valid[2]), .ReadData(rd2),
    .Fault(fault[2]));

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference storage, one byte per entry.
  logic [7:0] mem_m [3][2048];

  typedef struct {
    int          d;
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a;
    logic [63:0] wd;
    logic [63:0] ed;
    logic        ef;
  } vec_t;

  vec_t vecs[$];

  function automatic int dwid(input int d);
    return (d == 2) ? 64 : 32;
  endfunction

  function automatic int lat(input int d);
    case (d)
      0:       return 1;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [63:0] rdata_of(input int d);
    case (d)
      0:       return {32'h0, rd0};
      1:       return {32'h0, rd1};
      default: return rd2;
    endcase
  endfunction

  function automatic vec_t mk(input int d, input logic w, input logic [1:0] sz, input logic sg,
                              input logic [31:0] a, input logic [63:0] wd,
                              input logic [63:0] ed, input logic ef);
    vec_t v;
    v.d = d; v.w = w; v.sz = sz; v.sg = sg; v.a = a; v.wd = wd; v.ed = ed; v.ef = ef;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  task automatic drive(input int d, input logic v, input logic w, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a, input logic [63:0] wd);
    req_valid[d] = v; req_write[d] = w; req_size[d] = sz; req_signed[d] = sg; addr[d] = a;
    case (d)
      0:       wd0 = wd[31:0];
      1:       wd1 = wd[31:0];
      default: wd2 = wd;
    endcase
  endtask

  // One complete request/response; checks handshake timing along the way.
  task automatic access(input int d, input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [63:0] wd,
                        output logic [63:0] rd, output logic flt);
    int n, k;
    @(negedge clk);
    drive(d, 1'b1, w, sz, sg, a, wd);
    n = 0;
    while (!req_ready[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("accept_wait d%0d", d), 64'(n < 20), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid[d] = 1'b0;
    k = 0;
    while (!resp_valid[d] && k < 10) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("latency d%0d @%0h", d, a), 64'(k), 64'(lat(d)));
    check($sformatf("ready_after_resp d%0d", d), 64'(req_ready[d]), 64'd1);
    rd  = rdata_of(d);
    flt = fault[d];
  endtask

  // Behavioural reference: byte-granular memory, result built from bytes.
  task automatic model_op(input int d, input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [63:0] wd,
                          output logic [63:0] ed, output logic ef);
    int unsigned lane, n, ai;
    logic [63:0] v;
    lane = dwid(d) / 8;
    n    = 1 << sz;
    ai   = a;
    ef   = (sz == 2'd3 && dwid(d) == 32) || (ai % n != 0) || (ai / lane >= 256);
    ed   = '0;
    if (!ef) begin
      if (w) begin
        for (int k = 0; k < n; k++) mem_m[d][ai + k] = 8'(wd >> (8 * k));
      end else begin
        v = '0;
        for (int k = 0; k < n; k++) v = v | (64'(mem_m[d][ai + k]) << (8 * k));
        if (sg && (8 * n < dwid(d)) && v[8 * n - 1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
        if (dwid(d) == 32) v = v & 64'hFFFF_FFFF;
        ed = v;
      end
    end
  endtask

  task automatic model_check(input int d, input logic w, input logic [1:0] sz, input logic sg,
                             input logic [31:0] a, input logic [63:0] wd);
    logic [63:0] ed, rd;
    logic        ef, flt;
    model_op(d, w, sz, sg, a, wd, ed, ef);
    access(d, w, sz, sg, a, wd, rd, flt);
    check($sformatf("rand data d%0d w%0b sz%0d @%0h", d, w, sz, a), rd, ed);
    check($sformatf("rand fault d%0d w%0b sz%0d @%0h", d, w, sz, a), 64'(flt), 64'(ef));
  endtask

  logic [63:0] rd_v;
  logic        flt_v;
  logic        rec_ready [16];
  logic        rec_resp  [16];
  logic [63:0] rec_data  [16];

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst_n[d] = 1'b0;
      drive(d, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 64'h0);
    end

    // ---- reset state ----
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset ready d%0d", d), 64'(req_ready[d]), 64'd0);
      check($sformatf("reset resp d%0d", d), 64'(resp_valid[d]), 64'd0);
      check($sformatf("reset rdata d%0d", d), rdata_of(d), 64'd0);
      check($sformatf("reset fault d%0d", d), 64'(fault[d]), 64'd0);
      rst_n[d] = 1'b1;
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++)
      check($sformatf("ready after release d%0d", d), 64'(req_ready[d]), 64'd1);

    // ---- directed vectors ----
    vecs.push_back(mk(0, 1, 2, 0, 32'h10,  64'hDEADBEEF, 64'h0, 0));
    vecs.push_back(mk(0, 0, 2, 0, 32'h10,  64'h0, 64'hDEADBEEF, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h13,  64'h80, 64'h0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h13,  64'h0, 64'hFFFFFF80, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h13,  64'h0, 64'h00000080, 0));
    vecs.push_back(mk(0, 0, 2, 0, 32'h10,  64'h0, 64'h80ADBEEF, 0));
    vecs.push_back(mk(0, 0, 2, 1, 32'h10,  64'h0, 64'h80ADBEEF, 0));
    vecs.push_back(mk(0, 0, 1, 1, 32'h12,  64'h0, 64'hFFFF80AD, 0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h10,  64'h0, 64'h0000BEEF, 0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h11,  64'h0, 64'h0, 1));
    vecs.push_back(mk(0, 1, 2, 0, 32'h0,   64'h11223344, 64'h0, 0));
    vecs.push_back(mk(0, 1, 2, 0, 32'h400, 64'hCAFEF00D, 64'h0, 1));
    vecs.push_back(mk(0, 1, 2, 0, 32'h402, 64'hCAFEF00D, 64'h0, 1));
    vecs.push_back(mk(0, 0, 2, 0, 32'h0,   64'h0, 64'h11223344, 0));
    vecs.push_back(mk(0, 0, 2, 0, 32'h400, 64'h0, 64'h0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 32'h2,   64'hAAAA5566, 64'h0, 0));
    vecs.push_back(mk(0, 0, 2, 0, 32'h0,   64'h0, 64'h55663344, 0));
    vecs.push_back(mk(0, 1, 2, 0, 32'h8,   64'h0, 64'h0, 0));
    vecs.push_back(mk(0, 1, 3, 0, 32'h8,   64'hFFFFFFFFFFFFFFFF, 64'h0, 1));
    vecs.push_back(mk(0, 0, 2, 0, 32'h8,   64'h0, 64'h0, 0));
    vecs.push_back(mk(1, 1, 2, 0, 32'h3FC, 64'h12345678, 64'h0, 0));
    vecs.push_back(mk(1, 0, 2, 0, 32'h3FC, 64'h0, 64'h12345678, 0));
    vecs.push_back(mk(1, 0, 1, 1, 32'h3FE, 64'h0, 64'h00001234, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h3FD, 64'h0, 64'h00000056, 0));
    vecs.push_back(mk(1, 0, 2, 0, 32'h400, 64'h0, 64'h0, 1));
    vecs.push_back(mk(2, 1, 3, 0, 32'h8,   64'h0123456789ABCDEF, 64'h0, 0));
    vecs.push_back(mk(2, 0, 2, 0, 32'hC,   64'h0, 64'h01234567, 0));
    vecs.push_back(mk(2, 0, 2, 1, 32'h8,   64'h0, 64'hFFFFFFFF89ABCDEF, 0));
    vecs.push_back(mk(2, 0, 3, 0, 32'h8,   64'h0, 64'h0123456789ABCDEF, 0));
    vecs.push_back(mk(2, 0, 0, 1, 32'hF,   64'h0, 64'h01, 0));
    vecs.push_back(mk(2, 0, 0, 1, 32'h9,   64'h0, 64'hFFFFFFFFFFFFFFCD, 0));
    vecs.push_back(mk(2, 0, 1, 0, 32'hA,   64'h0, 64'h89AB, 0));
    vecs.push_back(mk(2, 1, 0, 0, 32'hE,   64'h5A, 64'h0, 0));
    vecs.push_back(mk(2, 0, 3, 0, 32'h8,   64'h0, 64'h015A456789ABCDEF, 0));
    vecs.push_back(mk(2, 0, 3, 0, 32'h4,   64'h0, 64'h0, 1));
    vecs.push_back(mk(2, 0, 2, 0, 32'h800, 64'h0, 64'h0, 1));

    foreach (vecs[i]) begin
      access(vecs[i].d, vecs[i].w, vecs[i].sz, vecs[i].sg, vecs[i].a, vecs[i].wd, rd_v, flt_v);
      check($sformatf("vec%0d data", i), rd_v, vecs[i].ed);
      check($sformatf("vec%0d fault", i), 64'(flt_v), 64'(vecs[i].ef));
    end

    // ---- back-to-back: ReqValid held high on the latency-3 instance ----
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h3FC, 64'h0);
    for (int t = 0; t < 16; t++) begin
      rec_ready[t] = req_ready[1];
      rec_resp[t]  = resp_valid[1];
      rec_data[t]  = rdata_of(1);
      @(negedge clk);
    end
    req_valid[1] = 1'b0;
    for (int t = 0; t < 16; t++) begin
      check($sformatf("b2b ready t%0d", t), 64'(rec_ready[t]), 64'((t % 4) == 0));
      check($sformatf("b2b resp t%0d", t), 64'(rec_resp[t]), 64'((t > 0) && ((t % 4) == 0)));
      if (t > 0 && (t % 4) == 0) check($sformatf("b2b data t%0d", t), rec_data[t], 64'h12345678);
    end
    repeat (6) @(negedge clk);

    // ---- reset while busy on the latency-3 instance ----
    drive(1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h3FC, 64'h0);
    begin
      int n;
      n = 0;
      while (!req_ready[1] && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("busy_reset accept_wait", 64'(n < 20), 64'd1);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    rst_n[1] = 1'b0;
    #1;
    check("busy_reset resp", 64'(resp_valid[1]), 64'd0);
    check("busy_reset ready", 64'(req_ready[1]), 64'd0);
    check("busy_reset rdata", rdata_of(1), 64'd0);
    check("busy_reset fault", 64'(fault[1]), 64'd0);
    @(negedge clk);
    rst_n[1] = 1'b1;
    check("busy_reset ready at release", 64'(req_ready[1]), 64'd0);
    @(negedge clk);
    check("busy_reset ready first edge", 64'(req_ready[1]), 64'd1);
    for (int t = 0; t < 5; t++) begin
      check($sformatf("busy_reset no resp t%0d", t), 64'(resp_valid[1]), 64'd0);
      @(negedge clk);
    end
    access(1, 1'b0, 2'd2, 1'b0, 32'h3FC, 64'h0, rd_v, flt_v);
    check("busy_reset memory kept", rd_v, 64'h12345678);

    // ---- random traffic against the reference model ----
    for (int d = 0; d < 3; d++) begin
      int unsigned lane;
      lane = dwid(d) / 8;
      for (int unsigned a = 0; a < 128; a += lane)
        model_check(d, 1'b1, (d == 2) ? 2'd3 : 2'd2, 1'b0, a, {$urandom, $urandom});
      for (int i = 0; i < 60; i++) begin
        logic [1:0]  sz;
        logic [31:0] a;
        sz = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) a = 256 * lane + $urandom_range(0, 63);
        else a = $urandom_range(0, 127);
        if ($urandom_range(0, 1) == 1) a = a & ~((32'd1 << sz) - 32'd1);
        model_check(d, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
                    {$urandom, $urandom});
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
